// File: rtl/ppu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ppu_pkg                                                   |
// | Purpose  : Shared types and constants for PPU memory access logic:   |
// |            port FSM states, address regions, region bases and the    |
// |            PPUDATA increment steps. Also provides the palette index  |
// |            helper so the aliasing rule lives in one place.           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package ppu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } vport_state_t;

  typedef enum logic [1:0] {
    REG_CHR = 2'd0,
    REG_NT  = 2'd1,
    REG_PAL = 2'd2
  } region_t;

  localparam logic [13:0] NT_BASE    = 14'h2000;
  localparam logic [13:0] PAL_BASE   = 14'h3F00;
  localparam logic [13:0] INC_ACROSS = 14'd1;
  localparam logic [13:0] INC_DOWN   = 14'd32;

  // Sprite-palette entry 0 of each group ($3F10/14/18/1C) shares storage
  // with the matching background entry, so bit 4 is dropped for them.
  function automatic logic [4:0] pal_index(input logic [13:0] v);
    return {v[4] & (v[1:0] != 2'b00), v[3:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ppu_vram_port_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ppu_vram_port_if                                          |
// | Purpose  : CPU-side request/ack bus into the PPU memory port.        |
// |            cpu_req   : request, held until cpu_ack                   |
// |            cpu_sel   : 0 = PPUADDR, 1 = PPUDATA                      |
// |            cpu_we    : 1 = write, 0 = read                           |
// |            cpu_wdata : write data                                    |
// |            cpu_rdata : read data, valid while cpu_ack is high        |
// |            cpu_ack   : completion, one clk_en period wide            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface ppu_vram_port_if;

  logic       cpu_req;
  logic       cpu_sel;
  logic       cpu_we;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_ack;

  modport master (
    output cpu_req, cpu_sel, cpu_we, cpu_wdata,
    input  cpu_rdata, cpu_ack
  );

  modport slave (
    input  cpu_req, cpu_sel, cpu_we, cpu_wdata,
    output cpu_rdata, cpu_ack
  );

endinterface
`default_nettype wire

// File: rtl/ppu_addr_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ppu_addr_decode                                           |
// | Purpose  : Combinational decode of a 14-bit PPU address into its     |
// |            target region and the per-target addresses.               |
// |            v         : PPU address                                   |
// |            mirror_v  : 1 = vertical, 0 = horizontal mirroring        |
// |            region    : CHR / nametable / palette                     |
// |            vram_addr : physical nametable address                    |
// |            chr_addr  : pattern address                               |
// |            pal_addr  : palette index (with aliasing)                 |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ppu_addr_decode
  import ppu_pkg::*;
#(
  parameter int VRAM_AW = 11,
  parameter int PPU_AW  = 14
) (
  input  wire  [PPU_AW-1:0]  v,
  input  wire                mirror_v,
  output region_t            region,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [12:0]        chr_addr,
  output logic [4:0]         pal_addr
);

  always_comb begin
    region = REG_NT;
    if (v < NT_BASE) begin
      region = REG_CHR;
    end else if (v >= PAL_BASE) begin
      region = REG_PAL;
    end
  end

  // The nametable address ignores v[13:12]. That makes $3000-$3EFF mirror
  // $2000-$2EFF, and it also means that when v points into palette space
  // this output already equals the nametable mirror of (v - $1000), which
  // is what the read buffer is loaded from on palette reads.
  assign vram_addr = {(mirror_v ? v[VRAM_AW-1] : v[VRAM_AW]), v[VRAM_AW-2:0]};
  assign chr_addr  = v[12:0];
  assign pal_addr  = pal_index(v);

endmodule
`default_nettype wire

// File: rtl/ppu_vram_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ppu_vram_port                                             |
// | Purpose  : CPU-facing initiator for PPU memory. Implements PPUADDR   |
// |            ($2006) with its write toggle and PPUDATA ($2007) with    |
// |            buffered reads and auto-increment, steering each access   |
// |            to CHR, nametable VRAM or palette RAM.                    |
// | Ports    : clk, clk_en, rst_n   : clock, PPU enable, async reset     |
// |            cpu (slave)          : request/ack bus                    |
// |            inc32, mirror_v      : PPUCTRL bit 2, mirroring mode      |
// |            clr_w                : PPUSTATUS read strobe              |
// |            vram_* / chr_* / pal_* : memory-side address/we/data      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ppu_vram_port
  import ppu_pkg::*;
#(
  parameter int VRAM_AW = 11,
  parameter int PPU_AW  = 14
) (
  input  wire                clk,
  input  wire                clk_en,
  input  wire                rst_n,
  ppu_vram_port_if.slave     cpu,
  input  wire                inc32,
  input  wire                mirror_v,
  input  wire                clr_w,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               vram_we,
  output logic [7:0]         vram_wdata,
  input  wire  [7:0]         vram_rdata,
  output logic [12:0]        chr_addr,
  output logic               chr_we,
  output logic [7:0]         chr_wdata,
  input  wire  [7:0]         chr_rdata,
  output logic [4:0]         pal_addr,
  output logic               pal_we,
  output logic [7:0]         pal_wdata,
  input  wire  [7:0]         pal_rdata
);

  vport_state_t      r_state;
  vport_state_t      w_state_next;
  logic              w_accept_data;
  logic              w_accept_addr;
  logic              w_access;
  logic              w_done;

  logic [PPU_AW-1:0] r_v;
  logic [PPU_AW-1:0] r_t;
  logic              r_w;
  logic [7:0]        r_read_buf;
  logic [7:0]        r_cpu_rdata;
  logic              r_op_sel;
  logic              r_op_we;
  logic [7:0]        r_op_wdata;

  region_t           w_region;

  ppu_addr_decode #(
    .VRAM_AW (VRAM_AW),
    .PPU_AW  (PPU_AW)
  ) u_decode (
    .v         (r_v),
    .mirror_v  (mirror_v),
    .region    (w_region),
    .vram_addr (vram_addr),
    .chr_addr  (chr_addr),
    .pal_addr  (pal_addr)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else if (clk_en) begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_accept_data = 1'b0;
    w_accept_addr = 1'b0;
    w_access      = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (cpu.cpu_req) begin
          if (cpu.cpu_sel) begin
            w_accept_data = 1'b1;
            w_state_next  = ACCESS;
          end else begin
            // PPUADDR completes at acceptance; no memory cycle needed.
            w_accept_addr = 1'b1;
            w_state_next  = DONE;
          end
        end
      end
      ACCESS: begin
        w_access     = 1'b1;
        w_state_next = DONE;
      end
      DONE: begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v         <= '0;
      r_t         <= '0;
      r_w         <= 1'b0;
      r_read_buf  <= 8'h00;
      r_cpu_rdata <= 8'h00;
      r_op_sel    <= 1'b0;
      r_op_we     <= 1'b0;
      r_op_wdata  <= 8'h00;
    end else if (clk_en) begin
      if (w_accept_data || w_accept_addr) begin
        r_op_sel   <= cpu.cpu_sel;
        r_op_we    <= cpu.cpu_we;
        r_op_wdata <= cpu.cpu_wdata;
      end

      if (w_accept_addr) begin
        if (!r_w) begin
          r_t[PPU_AW-1:8] <= cpu.cpu_wdata[PPU_AW-9:0];
        end else begin
          r_t[7:0] <= cpu.cpu_wdata;
          r_v      <= {r_t[PPU_AW-1:8], cpu.cpu_wdata};
        end
      end

      // A status read clears the toggle even when it lands on the same
      // edge as a PPUADDR write; the t/v update above still happens.
      if (clr_w) begin
        r_w <= 1'b0;
      end else if (w_accept_addr) begin
        r_w <= ~r_w;
      end

      if (w_access && !r_op_we) begin
        if (w_region == REG_PAL) begin
          // Palette reads bypass the buffer; the buffer instead picks up
          // the nametable byte underneath (see decoder note).
          r_cpu_rdata <= pal_rdata;
          r_read_buf  <= vram_rdata;
        end else begin
          r_cpu_rdata <= r_read_buf;
          r_read_buf  <= (w_region == REG_CHR) ? chr_rdata : vram_rdata;
        end
      end

      if (w_done && r_op_sel) begin
        r_v <= r_v + (inc32 ? INC_DOWN : INC_ACROSS);
      end
    end
  end

  // ------------------------------------------------------------ outputs
  assign cpu.cpu_ack   = w_done;
  assign cpu.cpu_rdata = r_cpu_rdata;

  assign vram_we    = w_access && r_op_we && (w_region == REG_NT);
  assign chr_we     = w_access && r_op_we && (w_region == REG_CHR);
  assign pal_we     = w_access && r_op_we && (w_region == REG_PAL);
  assign vram_wdata = r_op_wdata;
  assign chr_wdata  = r_op_wdata;
  assign pal_wdata  = r_op_wdata;

endmodule
`default_nettype wire

// File: tb/tb_ppu_vram_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ppu_vram_port                                          |
// | Purpose  : Scoreboard bench for ppu_vram_port. A behavioural model   |
// |            of the PPUADDR/PPUDATA rules predicts each ack (latency,  |
// |            read data) and each memory write; monitors compare.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_ppu_vram_port;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_n = 1'b0;
  logic        inc32 = 1'b0;
  logic        mirror_v = 1'b0;
  logic        clr_w = 1'b0;
  logic [10:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;
  logic [12:0] chr_addr;
  logic        chr_we;
  logic [7:0]  chr_wdata;
  logic [7:0]  chr_rdata;
  logic [4:0]  pal_addr;
  logic        pal_we;
  logic [7:0]  pal_wdata;
  logic [7:0]  pal_rdata;

  ppu_vram_port_if bus();

  ppu_vram_port dut (
    .clk        (clk),
    .clk_en     (clk_en),
    .rst_n      (rst_n),
    .cpu        (bus),
    .inc32      (inc32),
    .mirror_v   (mirror_v),
    .clr_w      (clr_w),
    .vram_addr  (vram_addr),
    .vram_we    (vram_we),
    .vram_wdata (vram_wdata),
    .vram_rdata (vram_rdata),
    .chr_addr   (chr_addr),
    .chr_we     (chr_we),
    .chr_wdata  (chr_wdata),
    .chr_rdata  (chr_rdata),
    .pal_addr   (pal_addr),
    .pal_we     (pal_we),
    .pal_wdata  (pal_wdata),
    .pal_rdata  (pal_rdata)
  );

  always #5 clk = ~clk;

  logic [1:0] en_cnt = 2'd0;
  always @(posedge clk) begin
    en_cnt <= en_cnt + 2'd1;
    clk_en <= (en_cnt == 2'd3);
  end

  // Memories seen by the DUT
  logic [7:0] tb_vram [2048];
  logic [7:0] tb_chr  [8192];
  logic [7:0] tb_pal  [32];
  assign vram_rdata = tb_vram[vram_addr];
  assign chr_rdata  = tb_chr[chr_addr];
  assign pal_rdata  = tb_pal[pal_addr];
  always @(posedge clk) begin
    if (clk_en) begin
      if (vram_we) tb_vram[vram_addr] <= vram_wdata;
      if (chr_we)  tb_chr[chr_addr]   <= chr_wdata;
      if (pal_we)  tb_pal[pal_addr]   <= pal_wdata;
    end
  end

  // Reference model state
  logic [7:0] ref_vram [2048];
  logic [7:0] ref_chr  [8192];
  logic [7:0] ref_pal  [32];
  int         mv = 0;
  int         mt = 0;
  bit         mw = 1'b0;
  logic [7:0] mbuf = 8'h00;

  typedef struct {bit is_read; logic [7:0] rdata; int lat;} ack_exp_t;
  typedef struct {int tgt; int addr; logic [7:0] data;} wr_exp_t;
  ack_exp_t ack_q[$];
  wr_exp_t  wr_q[$];

  int checks = 0;
  int errors = 0;
  int lat_cnt = 0;

  // Nametable layout: four logical 1 KB tables over two physical ones.
  function automatic int nt_index(input int a, input bit vert);
    int n;
    int tbl;
    n   = (a % 4096) / 1024;
    tbl = vert ? (n % 2) : (n / 2);
    return tbl * 1024 + (a % 1024);
  endfunction

  function automatic int pal_idx(input int a);
    int i;
    i = a % 32;
    if (i >= 16 && (i % 4) == 0) i = i - 16;
    return i;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Clock-enable edges seen while a request is held: 1 at acceptance.
  always @(posedge clk) begin
    if (!bus.cpu_req) lat_cnt <= 0;
    else if (clk_en) lat_cnt <= lat_cnt + 1;
  end

  // Ack monitor
  bit prev_ack = 1'b0;
  int ack_len = 0;
  always @(negedge clk) begin : ack_mon
    ack_exp_t e;
    if (bus.cpu_ack && !prev_ack) begin
      checks++;
      if (ack_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: got ack with no pending request");
      end else begin
        e = ack_q.pop_front();
        if (lat_cnt != e.lat) begin
          errors++;
          $display("FAIL ack_latency: got %0d expected %0d", lat_cnt, e.lat);
        end
        if (e.is_read) begin
          checks++;
          if (bus.cpu_rdata !== e.rdata) begin
            errors++;
            $display("FAIL read_data: got 0x%0h expected 0x%0h", bus.cpu_rdata, e.rdata);
          end
        end
      end
    end
    if (bus.cpu_ack) begin
      ack_len++;
    end else if (prev_ack) begin
      checks++;
      if (ack_len != 4) begin
        errors++;
        $display("FAIL ack_width: got %0d clks expected 4", ack_len);
      end
      ack_len = 0;
    end
    prev_ack = bus.cpu_ack;
  end

  // Write monitor: sampled in the cycle whose closing edge commits the write
  always @(negedge clk) begin : wr_mon
    wr_exp_t w;
    int at;
    int aa;
    logic [7:0] ad;
    if (clk_en && (vram_we || chr_we || pal_we)) begin
      checks++;
      at = chr_we ? 0 : (vram_we ? 1 : 2);
      aa = chr_we ? int'(chr_addr) : (vram_we ? int'(vram_addr) : int'(pal_addr));
      ad = chr_we ? chr_wdata : (vram_we ? vram_wdata : pal_wdata);
      if (int'(vram_we) + int'(chr_we) + int'(pal_we) != 1) begin
        errors++;
        $display("FAIL multi_we: got vram=%0b chr=%0b pal=%0b expected one", vram_we, chr_we, pal_we);
      end else if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got tgt=%0d addr=0x%0h data=0x%0h expected none", at, aa, ad);
      end else begin
        w = wr_q.pop_front();
        if (at != w.tgt || aa != w.addr || ad !== w.data) begin
          errors++;
          $display("FAIL write: got tgt=%0d addr=0x%0h data=0x%0h expected tgt=%0d addr=0x%0h data=0x%0h",
                   at, aa, ad, w.tgt, w.addr, w.data);
        end
      end
    end
  end

  // Predict an operation, then drive it until acked.
  task automatic issue(input bit sel, input bit we, input logic [7:0] d, input bit clr);
    ack_exp_t e;
    wr_exp_t  w;
    bit       got;
    e.is_read = 1'b0;
    e.rdata   = 8'h00;
    e.lat     = sel ? 2 : 1;
    if (!sel) begin
      if (!mw) begin
        mt = (int'(d) % 64) * 256 + (mt % 256);
        mw = 1'b1;
      end else begin
        mt = (mt / 256) * 256 + int'(d);
        mv = mt;
        mw = 1'b0;
      end
    end else begin
      if (we) begin
        if (mv < 'h2000) begin
          w.tgt = 0; w.addr = mv; ref_chr[mv] = d;
        end else if (mv < 'h3F00) begin
          w.tgt = 1; w.addr = nt_index(mv, mirror_v); ref_vram[w.addr] = d;
        end else begin
          w.tgt = 2; w.addr = pal_idx(mv); ref_pal[w.addr] = d;
        end
        w.data = d;
        wr_q.push_back(w);
      end else begin
        e.is_read = 1'b1;
        if (mv >= 'h3F00) begin
          e.rdata = ref_pal[pal_idx(mv)];
          mbuf    = ref_vram[nt_index(mv - 'h1000, mirror_v)];
        end else begin
          e.rdata = mbuf;
          mbuf    = (mv < 'h2000) ? ref_chr[mv] : ref_vram[nt_index(mv, mirror_v)];
        end
      end
      mv = (mv + (inc32 ? 32 : 1)) % 16384;
    end
    if (clr) mw = 1'b0;
    ack_q.push_back(e);

    @(posedge clk); #1;
    bus.cpu_req   = 1'b1;
    bus.cpu_sel   = sel;
    bus.cpu_we    = we;
    bus.cpu_wdata = d;
    clr_w         = clr;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (bus.cpu_ack) got = 1'b1;
    end
    bus.cpu_req = 1'b0;
    clr_w       = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack expected ack within 60 clks");
    end else begin
      for (int k = 0; k < 20 && bus.cpu_ack; k++) @(negedge clk);
    end
  endtask

  task automatic set_addr(input logic [7:0] hi, input logic [7:0] lo);
    issue(1'b0, 1'b1, hi, 1'b0);
    issue(1'b0, 1'b1, lo, 1'b0);
  endtask

  task automatic clr_pulse();
    @(posedge clk); #1;
    clr_w = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    clr_w = 1'b0;
    mw = 1'b0;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] x;
    bit got;
    bit seen;
    int r;
    bus.cpu_req   = 1'b0;
    bus.cpu_sel   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_wdata = 8'h00;
    for (int i = 0; i < 2048; i++) begin x = 8'($urandom); tb_vram[i] <= x; ref_vram[i] = x; end
    for (int i = 0; i < 8192; i++) begin x = 8'($urandom); tb_chr[i]  <= x; ref_chr[i]  = x; end
    for (int i = 0; i < 32; i++)   begin x = 8'($urandom); tb_pal[i]  <= x; ref_pal[i]  = x; end
    tb_vram[0] <= 8'h11; ref_vram[0] = 8'h11;
    tb_vram[1] <= 8'h22; ref_vram[1] = 8'h22;

    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("rst_ack",   int'(bus.cpu_ack), 0);
    chk("rst_rdata", int'(bus.cpu_rdata), 0);
    chk("rst_we",    int'(vram_we) + int'(chr_we) + int'(pal_we), 0);
    chk("rst_wdata", int'(vram_wdata) + int'(chr_wdata) + int'(pal_wdata), 0);
    chk("rst_chr_addr",  int'(chr_addr), 0);
    chk("rst_vram_addr", int'(vram_addr), 0);
    chk("rst_pal_addr",  int'(pal_addr), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Buffered reads from $2000: reset buffer, then $11, $22
    set_addr(8'h20, 8'h00);
    issue(1'b1, 1'b0, 8'h00, 1'b0);
    issue(1'b1, 1'b0, 8'h00, 1'b0);
    issue(1'b1, 1'b0, 8'h00, 1'b0);

    // $2108 under both mirroring modes
    set_addr(8'h21, 8'h08);
    issue(1'b1, 1'b1, 8'hAB, 1'b0);
    mirror_v = 1'b1;
    set_addr(8'h21, 8'h08);
    issue(1'b1, 1'b1, 8'hAC, 1'b0);

    // Mirroring
    set_addr(8'h2C, 8'h05);
    issue(1'b1, 1'b1, 8'h5A, 1'b0);
    mirror_v = 1'b0;
    set_addr(8'h2C, 8'h05);
    issue(1'b1, 1'b1, 8'h5B, 1'b0);
    set_addr(8'h24, 8'h05);
    issue(1'b1, 1'b1, 8'h5C, 1'b0);

    // Palette alias and unbuffered read; buffer then holds nametable byte
    set_addr(8'h3F, 8'h10);
    issue(1'b1, 1'b1, 8'h2A, 1'b0);
    set_addr(8'h3F, 8'h00);
    issue(1'b1, 1'b0, 8'h00, 1'b0);
    set_addr(8'h20, 8'h00);
    issue(1'b1, 1'b0, 8'h00, 1'b0);

    // Increment by 32 wraps to $0000
    inc32 = 1'b1;
    set_addr(8'h3F, 8'hE0);
    issue(1'b1, 1'b1, 8'h77, 1'b0);
    inc32 = 1'b0;
    issue(1'b1, 1'b1, 8'h99, 1'b0);

    // Toggle cleared by status read
    issue(1'b0, 1'b1, 8'h3F, 1'b0);
    clr_pulse();
    set_addr(8'h21, 8'h00);
    issue(1'b1, 1'b1, 8'h44, 1'b0);

    // Reset during the ACCESS period of a write
    set_addr(8'h23, 8'h45);
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_sel = 1'b1; bus.cpu_we = 1'b1; bus.cpu_wdata = 8'hEE;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk); #1;
      if (lat_cnt == 1) got = 1'b1;
    end
    chk("rst_reach_access", int'(got), 1);
    @(negedge clk);
    rst_n = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.cpu_ack || vram_we || chr_we || pal_we) seen = 1'b1;
    end
    chk("rst_abort_quiet", int'(seen), 0);
    chk("rst_abort_chr_addr", int'(chr_addr), 0);
    bus.cpu_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mv = 0; mt = 0; mw = 1'b0; mbuf = 8'h00;
    issue(1'b1, 1'b1, 8'h55, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      r        = $urandom_range(0, 9);
      mirror_v = 1'($urandom);
      inc32    = ($urandom_range(0, 3) == 0);
      x        = ($urandom_range(0, 3) == 0) ? 8'h3F : 8'($urandom);
      if (r < 3)      issue(1'b0, 1'b1, x, ($urandom_range(0, 9) == 0));
      else if (r < 6) issue(1'b1, 1'b1, x, ($urandom_range(0, 9) == 0));
      else if (r < 9) issue(1'b1, 1'b0, x, ($urandom_range(0, 9) == 0));
      else            clr_pulse();
    end

    repeat (12) @(posedge clk);
    chk("ack_queue_drained", ack_q.size(), 0);
    chk("wr_queue_drained",  wr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ppu_vram_port.md
Name: ppu_vram_port

Overview:
- CPU-facing initiator for PPU memory: implements PPUADDR ($2006) and PPUDATA ($2007) access semantics.
- Decodes the 14-bit PPU address into three targets:
  - pattern space (CHR bus),
  - nametable VRAM (2KB, write on clk_en, asynchronous read),
  - palette RAM.
- Provides the buffered-read behaviour and auto-increment.
- Sits between the PPU register file and the vram/palette/CHR memories; all state advances on the PPU clock enable.

Parameters:
- VRAM_AW, 11, nametable VRAM address width (2KB).
- PPU_AW, 14, PPU address space width.

Ports:
- clk  input  1  system clock
- clk_en  input  1  PPU clock enable (master/4); all state changes gated by it
- rst_n  input  1  asynchronous active-low reset
- cpu_req  input  1  access request; held high until cpu_ack
- cpu_sel  input  1  0=PPUADDR, 1=PPUDATA
- cpu_we  input  1  1=write, 0=read (reads valid only with cpu_sel=1)
- cpu_wdata  input  8  write data
- cpu_rdata  output  8  read result, valid while cpu_ack=1
- cpu_ack  output  1  completion, high for exactly one clk_en period
- inc32  input  1  PPUCTRL bit 2: increment 32 if 1, else 1
- mirror_v  input  1  1=vertical mirroring, 0=horizontal
- clr_w  input  1  PPUSTATUS read strobe; clears write toggle
- vram_addr  output  VRAM_AW  nametable address
- vram_we  output  1  nametable write enable
- vram_wdata  output  8  nametable write data
- vram_rdata  input  8  nametable read data (combinational)
- chr_addr  output  13  pattern address
- chr_we  output  1  pattern write enable
- chr_wdata  output  8  pattern write data
- chr_rdata  input  8  pattern read data (combinational)
- pal_addr  output  5  palette index
- pal_we  output  1  palette write enable
- pal_wdata  output  8  palette write data
- pal_rdata  input  8  palette read data (combinational)

Behaviour:
- Reset: the following all clear to 0:
  - registers v, t, w, read_buf, op latches;
  - state=IDLE;
  - outputs cpu_ack, cpu_rdata, all we, all wdata.
  - Address outputs reflect the decode of v=0.
- Reset mid-operation aborts the operation; no write is issued and no ack is produced.
- States: IDLE, ACCESS, DONE; transitions only on clk_en.
- IDLE:
  - On cpu_req with cpu_sel=1: latch sel, we and wdata, then go to ACCESS.
  - On cpu_req with cpu_sel=0: perform the address write, then go to DONE.
- ACCESS (one clk_en period):
  - Address outputs are driven from the decode of v.
  - The target's we=1 only on a write, and only for the decoded target.
  - Read data is captured at the end of this period.
  - Next state is DONE.
- DONE:
  - cpu_ack=1.
  - On leaving DONE: if the op was PPUDATA, v <= (v + (inc32 ? 32 : 1)) mod 2^14.
  - Next state is IDLE.
- Latency:
  - PPUDATA: ack in the 2nd clk_en period after acceptance.
  - PPUADDR: ack in the 1st clk_en period after acceptance.
  - cpu_req is ignored outside IDLE.
- PPUADDR writes:
  - w=0: t[13:8] <= wdata[5:0] (wdata[7:6] dropped), then w <= 1.
  - w=1: t[7:0] <= wdata, v <= new t, then w <= 0.
- clr_w (any clk_en period): w <= 0. If it coincides with a PPUADDR update, the t/v update happens as computed and w ends at 0 (clr_w wins).
- Address decode on v:
  - 0000-1FFF: CHR, chr_addr=v[12:0].
  - 2000-3EFF: nametable region (3000-3EFF mirrors 2000-2EFF).
    - vram_addr={mirror_v ? v[10] : v[11], v[9:0]}.
  - 3F00-3FFF: palette.
    - pal_addr=v[4:0], except bit4 forced 0 when v[1:0]==0 (3F10/14/18/1C alias 3F00/04/08/0C).
- Writes: wdata goes to the decoded target only; other targets' we=0.
- Reads, v < 3F00: cpu_rdata <= read_buf (stale value), read_buf <= target data.
- Reads, v >= 3F00:
  - cpu_rdata <= pal_rdata, with no buffering delay.
  - read_buf <= vram_rdata at the nametable mirror of (v - 1000), i.e. vram_addr decoded with v[13:12] treated as 2'b10.
- Wrap: v = 3FFF + 1 -> 0000; v = 3FE0 + 32 -> 0000.
- The write enables are high for exactly one clk_en edge per write. There are no writes in IDLE or DONE.

Decomposition:
- Package ppu_pkg:
  - state enum vport_state_t {IDLE, ACCESS, DONE};
  - region enum region_t {REG_CHR, REG_NT, REG_PAL};
  - constants NT_BASE=14'h2000, PAL_BASE=14'h3F00, INC_ACROSS=1, INC_DOWN=32.
- Sub-module ppu_addr_decode: combinational v + mirror_v -> region, vram_addr, chr_addr, pal_addr (with palette aliasing and the read-buffer nametable override). It is reused later by the rendering fetch unit.

Test Plan:
- Reset, then PPUADDR writes 0x21, 0x08 -> v=0x2108. PPUDATA write 0xAB -> vram_we pulses once with vram_addr=0x108 (vertical) or 0x108 (horizontal, since v[11]=0); v becomes 0x2109; ack arrives exactly 2 clk_en periods after acceptance.
- Mirroring: v=0x2C05 with mirror_v=1 -> vram_addr=0x405; with mirror_v=0 -> 0x405 via v[11]. v=0x2405 with mirror_v=0 -> vram_addr=0x005.
- Buffered read: preload VRAM[0x000]=0x11, VRAM[0x001]=0x22; set v=0x2000; three reads return 0x00 (reset buffer), 0x11, 0x22.
- Palette: write 0x3F10 <- 0x2A -> pal_addr=0x00. Read 0x3F00 -> 0x2A returned immediately; read_buf loaded from vram_addr decoded from 0x2F00.
- inc32=1 from v=0x3FE0: one PPUDATA write -> v=0x0000. A subsequent write goes to chr_addr=0x0000.
- Toggle control: single PPUADDR write 0x3F, then clr_w, then 0x21, 0x00 -> v=0x2100. Separately, assert rst_n low during ACCESS of a write -> no we pulse, no ack, v=0.
